// File: rtl/palette_upload_ctrl.sv
// palette_upload_ctrl: loads a 64 x RGB888 user palette from the ioctl download
// stream into a 64 x 15 BGR555 single-port RAM and shares that port with video reads.
// Optional build macro: PAL_CHECKSUM_EN adds a 16-bit running sum of accepted bytes.
//
// Handshake: ioctl_wr is a one-cycle byte strobe, accepted when ioctl_wait=0.
// ioctl_wait rises only while a completed entry is still waiting for the RAM port
// and the next byte would complete another entry. vid_rd always owns the RAM port
// in its cycle, and read data appears on vid_data one cycle later.
module palette_upload_ctrl #(
   parameter logic [7:0] PAL_INDEX  = 8'd2,
   parameter logic [3:0] CUSTOM_SEL = 4'd14,
   parameter int         ENTRIES    = 64
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        ioctl_download,
   input  logic [7:0]                  ioctl_index,
   input  logic                        ioctl_wr,
   input  logic [7:0]                  ioctl_dout,
   output logic                        ioctl_wait,
   input  logic [3:0]                  pal_sel,
   input  logic                        vid_rd,
   input  logic [$clog2(ENTRIES)-1:0]  vid_addr,
   output logic [14:0]                 vid_data,
   output logic                        use_custom,
   output logic                        load_err,
   output logic [15:0]                 pal_checksum,
   output logic [1:0]                  dbg_state
);

   localparam int AW = $clog2(ENTRIES);
   localparam int EW = $clog2(ENTRIES + 1);
   localparam logic [EW-1:0] ENTRY_END = EW'(ENTRIES);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     phase_q, phase_d;
   logic [EW-1:0]  entry_q, entry_d;
   logic [4:0]     r_q, r_d;
   logic [4:0]     g_q, g_d;
   logic           pend_valid_q, pend_valid_d;
   logic [AW-1:0]  pend_addr_q, pend_addr_d;
   logic [14:0]    pend_data_q, pend_data_d;
   logic           load_err_q, load_err_d;
   logic           custom_valid_q, custom_valid_d;
   logic           use_custom_q, use_custom_d;
   logic [14:0]    vid_data_q, vid_data_d;
   logic [14:0]    mem_q [ENTRIES];

   logic active;
   logic wait_w;
   logic commit;
   logic byte_ok;

   assign active = ioctl_download && (ioctl_index == PAL_INDEX);
   assign wait_w = pend_valid_q && (phase_q == 2'd2);
   // Video reads win the port; a pending write slips into the next free cycle.
   assign commit = pend_valid_q && !vid_rd;

   // Next-state, byte assembly, pending-write and status logic.
   always_comb begin
      state_d        = state_q;
      phase_d        = phase_q;
      entry_d        = entry_q;
      r_d            = r_q;
      g_d            = g_q;
      pend_valid_d   = pend_valid_q && !commit;
      pend_addr_d    = pend_addr_q;
      pend_data_d    = pend_data_q;
      load_err_d     = load_err_q;
      custom_valid_d = custom_valid_q;
      byte_ok        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (active) begin
               state_d        = ST_LOAD;
               phase_d        = 2'd0;
               entry_d        = '0;
               load_err_d     = 1'b0;
               custom_valid_d = 1'b0;
            end
         end
         ST_LOAD: begin
            if (!active) begin
               state_d = ST_FLUSH;
            end else if (ioctl_wr) begin
               if (wait_w || (entry_q == ENTRY_END)) begin
                  load_err_d = 1'b1;
               end else begin
                  byte_ok = 1'b1;
                  case (phase_q)
                     2'd0: begin
                        r_d     = ioctl_dout[7:3];
                        phase_d = 2'd1;
                     end
                     2'd1: begin
                        g_d     = ioctl_dout[7:3];
                        phase_d = 2'd2;
                     end
                     2'd2: begin
                        pend_valid_d = 1'b1;
                        pend_addr_d  = entry_q[AW-1:0];
                        pend_data_d  = {ioctl_dout[7:3], g_q, r_q};
                        entry_d      = entry_q + 1'b1;
                        phase_d      = 2'd0;
                     end
                     default: phase_d = 2'd0;
                  endcase
               end
            end
         end
         ST_FLUSH: begin
            // A partial entry is simply never written; only whole loads validate.
            if (!pend_valid_q) begin
               state_d = ST_IDLE;
               if ((entry_q == ENTRY_END) && (phase_q == 2'd0) && !load_err_q) begin
                  custom_valid_d = 1'b1;
               end else begin
                  load_err_d     = 1'b1;
                  custom_valid_d = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      use_custom_d = custom_valid_q && (pal_sel == CUSTOM_SEL);
      vid_data_d   = vid_rd ? mem_q[vid_addr] : vid_data_q;
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         phase_q        <= 2'd0;
         entry_q        <= '0;
         r_q            <= '0;
         g_q            <= '0;
         pend_valid_q   <= 1'b0;
         pend_addr_q    <= '0;
         pend_data_q    <= '0;
         load_err_q     <= 1'b0;
         custom_valid_q <= 1'b0;
         use_custom_q   <= 1'b0;
         vid_data_q     <= '0;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         entry_q        <= entry_d;
         r_q            <= r_d;
         g_q            <= g_d;
         pend_valid_q   <= pend_valid_d;
         pend_addr_q    <= pend_addr_d;
         pend_data_q    <= pend_data_d;
         load_err_q     <= load_err_d;
         custom_valid_q <= custom_valid_d;
         use_custom_q   <= use_custom_d;
         vid_data_q     <= vid_data_d;
      end
   end

   // Palette RAM write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (commit) mem_q[pend_addr_q] <= pend_data_q;
   end

`ifdef PAL_CHECKSUM_EN
   logic [15:0] csum_q, csum_d;

   // Running sum of accepted bytes, restarted when a download begins.
   always_comb begin
      csum_d = csum_q;
      if ((state_q == ST_IDLE) && active) csum_d = 16'h0000;
      else if (byte_ok)                   csum_d = csum_q + {8'h00, ioctl_dout};
   end

   // Checksum register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) csum_q <= 16'h0000;
      else          csum_q <= csum_d;
   end

   assign pal_checksum = csum_q;
`else
   assign pal_checksum = 16'h0000;
`endif

   // Low colour bits are truncated by design; byte_ok only feeds the checksum.
   logic unused_sig;
   assign unused_sig = ^{byte_ok, ioctl_dout[2:0]};

   assign ioctl_wait = wait_w;
   assign vid_data   = vid_data_q;
   assign use_custom = use_custom_q;
   assign load_err   = load_err_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_palette_upload_ctrl.sv
// Testbench for palette_upload_ctrl. Honours PAL_CHECKSUM_EN for checksum expectations.
`timescale 1ns/1ps
module tb_palette_upload_ctrl;

   localparam logic [7:0] PAL_INDEX  = 8'd2;
   localparam logic [3:0] CUSTOM_SEL = 4'd14;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'd0;
   logic        ioctl_wr = 1'b0;
   logic [7:0]  ioctl_dout = 8'd0;
   logic        ioctl_wait;
   logic [3:0]  pal_sel = 4'd0;
   logic        vid_rd = 1'b0;
   logic [5:0]  vid_addr = 6'd0;
   logic [14:0] vid_data;
   logic        use_custom;
   logic        load_err;
   logic [15:0] pal_checksum;
   logic [1:0]  dbg_state;

   int tests_run = 0;
   int tests_failed = 0;

   logic [14:0] model_mem [64];
   logic [14:0] exp_q [$];
   logic [7:0]  dl_bytes [256];
   logic [15:0] exp_sum = 16'h0000;

   palette_upload_ctrl #(
      .PAL_INDEX (PAL_INDEX),
      .CUSTOM_SEL(CUSTOM_SEL),
      .ENTRIES   (64)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .ioctl_download(ioctl_download),
      .ioctl_index   (ioctl_index),
      .ioctl_wr      (ioctl_wr),
      .ioctl_dout    (ioctl_dout),
      .ioctl_wait    (ioctl_wait),
      .pal_sel       (pal_sel),
      .vid_rd        (vid_rd),
      .vid_addr      (vid_addr),
      .vid_data      (vid_data),
      .use_custom    (use_custom),
      .load_err      (load_err),
      .pal_checksum  (pal_checksum),
      .dbg_state     (dbg_state)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [14:0] pack(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      return {b[7:3], g[7:3], r[7:3]};
   endfunction

   function automatic logic [15:0] exp_csum();
`ifdef PAL_CHECKSUM_EN
      return exp_sum;
`else
      return 16'h0000;
`endif
   endfunction

   // Drivers: everything changes 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard;
      guard = 0;
      while (ioctl_wait && guard < 20) begin
         tick();
         guard++;
      end
      if (guard >= 20) begin
         tests_run++;
         tests_failed++;
         $display("FAIL wait_timeout: ioctl_wait=%0b held for %0d cycles, required release", ioctl_wait, guard);
      end
      ioctl_dout = b;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   task automatic download(input int n, input logic [7:0] idx);
      int guard;
      int lim;
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      tick();
      for (int k = 0; k < n; k++) send_byte(dl_bytes[k]);
      ioctl_download = 1'b0;
      tick();
      guard = 0;
      while (dbg_state != 2'd0 && guard < 20) begin
         tick();
         guard++;
      end
      tests_run++;
      if (dbg_state !== 2'd0) begin
         tests_failed++;
         $display("FAIL download_idle: dbg_state=%0d, required 0", dbg_state);
      end
      tick();
      tick();
      if (idx == PAL_INDEX) begin
         lim = (n < 192) ? n : 192;
         exp_sum = 16'h0000;
         for (int k = 0; k < lim; k++) exp_sum = exp_sum + {8'h00, dl_bytes[k]};
         for (int e = 0; e < lim / 3; e++)
            model_mem[e] = pack(dl_bytes[3*e], dl_bytes[3*e+1], dl_bytes[3*e+2]);
      end
   endtask

   // Scoreboard read: expectation queued on drive, popped when data is valid.
   task automatic do_read(input logic [5:0] addr, input string name);
      logic [14:0] exp;
      vid_addr = addr;
      vid_rd   = 1'b1;
      exp_q.push_back(model_mem[addr]);
      tick();
      vid_rd = 1'b0;
      exp = exp_q.pop_front();
      tests_run++;
      if (vid_data !== exp) begin
         tests_failed++;
         $display("FAIL %s addr=%0d: vid_data=%h, required %h", name, addr, vid_data, exp);
      end
      tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      tests_run += 6;
      if (ioctl_wait !== 1'b0)     begin tests_failed++; $display("FAIL reset_wait: %b, required 0", ioctl_wait); end
      if (vid_data !== 15'h0)      begin tests_failed++; $display("FAIL reset_vid_data: %h, required 0", vid_data); end
      if (use_custom !== 1'b0)     begin tests_failed++; $display("FAIL reset_use_custom: %b, required 0", use_custom); end
      if (load_err !== 1'b0)       begin tests_failed++; $display("FAIL reset_load_err: %b, required 0", load_err); end
      if (pal_checksum !== 16'h0)  begin tests_failed++; $display("FAIL reset_checksum: %h, required 0", pal_checksum); end
      if (dbg_state !== 2'd0)      begin tests_failed++; $display("FAIL reset_state: %0d, required 0", dbg_state); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_full_load();
      pal_sel = CUSTOM_SEL;
      for (int k = 0; k < 192; k++) dl_bytes[k] = 8'(k);
      download(192, PAL_INDEX);
      tests_run += 3;
      if (load_err !== 1'b0)         begin tests_failed++; $display("FAIL t1_load_err: %b, required 0", load_err); end
      if (use_custom !== 1'b1)       begin tests_failed++; $display("FAIL t1_use_custom: %b, required 1", use_custom); end
      if (pal_checksum !== exp_csum()) begin tests_failed++; $display("FAIL t1_checksum: %h, required %h", pal_checksum, exp_csum()); end
      do_read(6'd0, "t1_read");
      do_read(6'd1, "t1_read");
      do_read(6'd2, "t1_read");
      do_read(6'd31, "t1_read");
      do_read(6'd63, "t1_read");
      tick();
      tick();
      tests_run++;
      if (vid_data !== pack(8'd189, 8'd190, 8'd191)) begin
         tests_failed++;
         $display("FAIL t1_hold: vid_data=%h, required %h", vid_data, pack(8'd189, 8'd190, 8'd191));
      end
      pal_sel = 4'd3;
      tick();
      tests_run++;
      if (use_custom !== 1'b0) begin tests_failed++; $display("FAIL t1_sel_off: %b, required 0", use_custom); end
      pal_sel = CUSTOM_SEL;
      tick();
      tests_run++;
      if (use_custom !== 1'b1) begin tests_failed++; $display("FAIL t1_sel_on: %b, required 1", use_custom); end
   endtask

   task automatic test_read_during_load();
      dl_bytes[0] = 8'hF8;
      dl_bytes[1] = 8'h00;
      dl_bytes[2] = 8'h00;
      fork
         download(3, PAL_INDEX);
         begin
            for (int a = 1; a <= 12; a++) do_read(6'(a), "t2_read_during");
         end
         begin
            int run;
            int max_run;
            run = 0;
            max_run = 0;
            for (int c = 0; c < 30; c++) begin
               tick();
               if (ioctl_wait) run++;
               else run = 0;
               if (run > max_run) max_run = run;
            end
            tests_run++;
            if (max_run > 1) begin
               tests_failed++;
               $display("FAIL t2_wait_pulse: longest ioctl_wait run=%0d, required <=1", max_run);
            end
         end
      join
      do_read(6'd0, "t2_entry0");
      tests_run += 3;
      if (vid_data !== 15'h001F)     begin tests_failed++; $display("FAIL t2_entry0_const: %h, required 001f", vid_data); end
      if (load_err !== 1'b1)         begin tests_failed++; $display("FAIL t2_load_err: %b, required 1", load_err); end
      if (use_custom !== 1'b0)       begin tests_failed++; $display("FAIL t2_use_custom: %b, required 0", use_custom); end
   endtask

   task automatic test_overlength();
      for (int k = 0; k < 200; k++) dl_bytes[k] = 8'($urandom_range(0, 255));
      download(200, PAL_INDEX);
      tests_run += 3;
      if (load_err !== 1'b1)           begin tests_failed++; $display("FAIL t3_load_err: %b, required 1", load_err); end
      if (use_custom !== 1'b0)         begin tests_failed++; $display("FAIL t3_use_custom: %b, required 0", use_custom); end
      if (pal_checksum !== exp_csum()) begin tests_failed++; $display("FAIL t3_checksum: %h, required %h", pal_checksum, exp_csum()); end
      do_read(6'd0, "t3_read");
      do_read(6'd63, "t3_read");
   endtask

   task automatic test_abort_and_reload();
      for (int k = 0; k < 100; k++) dl_bytes[k] = 8'($urandom_range(0, 255));
      download(100, PAL_INDEX);
      tests_run += 2;
      if (load_err !== 1'b1)   begin tests_failed++; $display("FAIL t4_abort_err: %b, required 1", load_err); end
      if (use_custom !== 1'b0) begin tests_failed++; $display("FAIL t4_abort_use: %b, required 0", use_custom); end
      do_read(6'd32, "t4_last_whole");
      do_read(6'd33, "t4_partial_skipped");
      for (int k = 0; k < 192; k++) dl_bytes[k] = 8'($urandom_range(0, 255));
      download(192, PAL_INDEX);
      tests_run += 2;
      if (load_err !== 1'b0)   begin tests_failed++; $display("FAIL t4_reload_err: %b, required 0", load_err); end
      if (use_custom !== 1'b1) begin tests_failed++; $display("FAIL t4_reload_use: %b, required 1", use_custom); end
      do_read(6'd5, "t4_reload_read");
   endtask

   task automatic test_wrong_index();
      for (int k = 0; k < 6; k++) dl_bytes[k] = 8'($urandom_range(0, 255));
      download(6, 8'd3);
      tests_run += 3;
      if (load_err !== 1'b0)           begin tests_failed++; $display("FAIL idx_load_err: %b, required 0", load_err); end
      if (use_custom !== 1'b1)         begin tests_failed++; $display("FAIL idx_use_custom: %b, required 1", use_custom); end
      if (pal_checksum !== exp_csum()) begin tests_failed++; $display("FAIL idx_checksum: %h, required %h", pal_checksum, exp_csum()); end
      do_read(6'd0, "idx_read");
      do_read(6'd1, "idx_read");
   endtask

   task automatic test_reset_mid_load();
      logic [7:0] b [51];
      for (int k = 0; k < 51; k++) b[k] = 8'($urandom_range(0, 255));
      ioctl_index    = PAL_INDEX;
      ioctl_download = 1'b1;
      tick();
      for (int k = 0; k < 51; k++) send_byte(b[k]);
      reset_n = 1'b0;
      #1;
      tests_run += 6;
      if (ioctl_wait !== 1'b0)    begin tests_failed++; $display("FAIL t5_wait: %b, required 0", ioctl_wait); end
      if (vid_data !== 15'h0)     begin tests_failed++; $display("FAIL t5_vid_data: %h, required 0", vid_data); end
      if (use_custom !== 1'b0)    begin tests_failed++; $display("FAIL t5_use_custom: %b, required 0", use_custom); end
      if (load_err !== 1'b0)      begin tests_failed++; $display("FAIL t5_load_err: %b, required 0", load_err); end
      if (pal_checksum !== 16'h0) begin tests_failed++; $display("FAIL t5_checksum: %h, required 0", pal_checksum); end
      if (dbg_state !== 2'd0)     begin tests_failed++; $display("FAIL t5_state: %0d, required 0", dbg_state); end
      ioctl_download = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      tick();
      for (int e = 0; e < 16; e++) model_mem[e] = pack(b[3*e], b[3*e+1], b[3*e+2]);
      tests_run++;
      if (use_custom !== 1'b0) begin tests_failed++; $display("FAIL t5_after_use: %b, required 0", use_custom); end
      do_read(6'd15, "t5_written");
      do_read(6'd16, "t5_pending_lost");
   endtask

   task automatic test_checksum();
      for (int k = 0; k < 192; k++) dl_bytes[k] = 8'hFF;
      download(192, PAL_INDEX);
      tests_run += 2;
`ifdef PAL_CHECKSUM_EN
      if (pal_checksum !== 16'hBF40) begin tests_failed++; $display("FAIL t6_checksum: %h, required bf40", pal_checksum); end
`else
      if (pal_checksum !== 16'h0000) begin tests_failed++; $display("FAIL t6_checksum: %h, required 0000", pal_checksum); end
`endif
      if (load_err !== 1'b0) begin tests_failed++; $display("FAIL t6_load_err: %b, required 0", load_err); end
      for (int c = 0; c < 4; c++) tick();
      tests_run++;
      if (pal_checksum !== exp_csum()) begin tests_failed++; $display("FAIL t6_frozen: %h, required %h", pal_checksum, exp_csum()); end
      do_read(6'd40, "t6_read");
   endtask

   // Test sequence and final report.
   initial begin
      test_reset();
      test_full_load();
      test_read_during_load();
      test_overlength();
      test_abort_and_reload();
      test_wrong_index();
      test_reset_mid_load();
      test_checksum();
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
